tmr_updown_counter: RTL and testbench

//   Triple-modular-redundant up/down modulo counter with load, per-lane fault

---
 rtl/tmr_updown_counter.sv | 148 ++++++++++++++
 tb/tb_tmr_updown_counter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_updown_counter.sv
// tmr_updown_counter: triple-modular-redundant up/down modulo counter.
// Three replica registers are resolved by a bitwise majority voter, and every
// replica reloads from the voted next value each clock, so a single-lane upset
// is scrubbed within one cycle. It also provides per-lane saturating error
// counters, a sticky uncorrectable flag and a fault-injection port.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   enable, up_dn  step the count this cycle; 1 = up, 0 = down
//   load, load_val synchronous load, takes priority over enable, clipped to MAX_VAL
//   inj_en         fault-injection strobe
//   inj_lane       target replica 0..2 (3 = no-op)
//   inj_mask       XOR mask for the target replica's next value
//   err_clr        clears the error counters and the uncorrectable flag
//   q_out          voted count (no added latency)
//   wrap           registered one-cycle pulse on a terminal-count rollover
//   fault_lane     combinational; bit i set when replica i differs from the vote
//   err_cnt        per-lane saturating error counts, lane i at [i*ERR_CNT_W +: ERR_CNT_W]
//   uncorrectable  sticky; set when all three replicas are pairwise different
module tmr_updown_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_VAL   = (2**WIDTH) - 1,
  parameter int unsigned ERR_CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   up_dn,
  input  logic                   load,
  input  logic [WIDTH-1:0]       load_val,
  input  logic                   inj_en,
  input  logic [1:0]             inj_lane,
  input  logic [WIDTH-1:0]       inj_mask,
  input  logic                   err_clr,
  output logic [WIDTH-1:0]       q_out,
  output logic                   wrap,
  output logic [2:0]             fault_lane,
  output logic [3*ERR_CNT_W-1:0] err_cnt,
  output logic                   uncorrectable
);

  localparam logic [WIDTH-1:0]     MAX_V   = WIDTH'(MAX_VAL);
  localparam logic [ERR_CNT_W-1:0] ERR_SAT = '1;

  logic [WIDTH-1:0]     r0, r1, r2;
  logic [WIDTH-1:0]     vote;
  logic [WIDTH-1:0]     nxt;
  logic                 wrap_nxt;
  logic [2:0]           inj_hit;
  logic                 all_differ;
  logic [ERR_CNT_W-1:0] err_q [3];

  // Bitwise majority vote and per-lane disagreement flags
  assign vote       = (r0 & r1) | (r0 & r2) | (r1 & r2);
  assign q_out      = vote;
  assign fault_lane = {(r2 != vote), (r1 != vote), (r0 != vote)};
  assign all_differ = (r0 != r1) && (r0 != r2) && (r1 != r2);

  // Next value is derived from the vote only, so each lane is scrubbed every cycle.
  // An out-of-range vote (multi-lane upset) steps up to 0 without a wrap.
  always_comb begin
    nxt      = vote;
    wrap_nxt = 1'b0;
    if (load) begin
      nxt = (load_val >= MAX_V) ? MAX_V : load_val;
    end else if (enable) begin
      if (up_dn) begin
        if (vote >= MAX_V) begin
          nxt      = '0;
          wrap_nxt = (vote == MAX_V);
        end else begin
          nxt = vote + WIDTH'(1);
        end
      end else begin
        if (vote == '0) begin
          nxt      = MAX_V;
          wrap_nxt = 1'b1;
        end else begin
          nxt = vote - WIDTH'(1);
        end
      end
    end
  end

  // Injection decode; inj_lane == 3 matches no lane
  always_comb begin
    inj_hit = 3'b000;
    for (int i = 0; i < 3; i++) begin
      inj_hit[i] = inj_en && (inj_lane == 2'(i));
    end
  end

  // Replica registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0 <= '0;
      r1 <= '0;
      r2 <= '0;
    end else begin
      r0 <= inj_hit[0] ? (nxt ^ inj_mask) : nxt;
      r1 <= inj_hit[1] ? (nxt ^ inj_mask) : nxt;
      r2 <= inj_hit[2] ? (nxt ^ inj_mask) : nxt;
    end
  end

  // Rollover pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_nxt;
    end
  end

  // Saturating per-lane error counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        err_q[i] <= '0;
      end
    end else if (err_clr) begin
      for (int i = 0; i < 3; i++) begin
        err_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (fault_lane[i] && (err_q[i] != ERR_SAT)) begin
          err_q[i] <= err_q[i] + ERR_CNT_W'(1);
        end
      end
    end
  end

  // Sticky uncorrectable flag; a new set condition beats err_clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uncorrectable <= 1'b0;
    end else begin
      uncorrectable <= all_differ | (uncorrectable & ~err_clr);
    end
  end

  // Pack the lane counters onto the output bus
  for (genvar g = 0; g < 3; g++) begin : g_err_out
    assign err_cnt[g*ERR_CNT_W +: ERR_CNT_W] = err_q[g];
  end

endmodule

// File: tb/tb_tmr_updown_counter.sv
// tb_tmr_updown_counter: directed table-driven bench for tmr_updown_counter
// (WIDTH=8, MAX_VAL=9, ERR_CNT_W=4), plus hand-written fault sequences.
module tb_tmr_updown_counter;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned MAX_VAL   = 9;
  localparam int unsigned ERR_CNT_W = 4;

  logic                   clk;
  logic                   rst;
  logic                   enable;
  logic                   up_dn;
  logic                   load;
  logic [WIDTH-1:0]       load_val;
  logic                   inj_en;
  logic [1:0]             inj_lane;
  logic [WIDTH-1:0]       inj_mask;
  logic                   err_clr;
  logic [WIDTH-1:0]       q_out;
  logic                   wrap;
  logic [2:0]             fault_lane;
  logic [3*ERR_CNT_W-1:0] err_cnt;
  logic                   uncorrectable;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       load;
    logic [7:0] load_val;
    logic       enable;
    logic       up_dn;
    logic [7:0] exp_q;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs [16];

  tmr_updown_counter #(
    .WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val), .inj_en(inj_en), .inj_lane(inj_lane),
    .inj_mask(inj_mask), .err_clr(err_clr), .q_out(q_out), .wrap(wrap),
    .fault_lane(fault_lane), .err_cnt(err_cnt), .uncorrectable(uncorrectable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] lane_err(input int i);
    logic [3*ERR_CNT_W-1:0] e;
    e = err_cnt;
    return e[i*ERR_CNT_W +: ERR_CNT_W];
  endfunction

  // One clock edge, then settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enable   = 1'b0;
    up_dn    = 1'b0;
    load     = 1'b0;
    load_val = '0;
    inj_en   = 1'b0;
    inj_lane = 2'd0;
    inj_mask = '0;
    err_clr  = 1'b0;
  endtask

  task automatic inject(input logic [1:0] lane, input logic [7:0] mask);
    inj_en   = 1'b1;
    inj_lane = lane;
    inj_mask = mask;
  endtask

  initial begin
    //           load  val     en    up    q      wrap
    vecs[0]  = '{1'b1, 8'd8,   1'b0, 1'b0, 8'd8, 1'b0};
    vecs[1]  = '{1'b0, 8'd0,   1'b1, 1'b1, 8'd9, 1'b0};
    vecs[2]  = '{1'b0, 8'd0,   1'b1, 1'b1, 8'd0, 1'b1};
    vecs[3]  = '{1'b0, 8'd0,   1'b0, 1'b0, 8'd0, 1'b0};
    vecs[4]  = '{1'b1, 8'd200, 1'b0, 1'b0, 8'd9, 1'b0};
    vecs[5]  = '{1'b1, 8'd0,   1'b0, 1'b0, 8'd0, 1'b0};
    vecs[6]  = '{1'b0, 8'd0,   1'b1, 1'b0, 8'd9, 1'b1};
    vecs[7]  = '{1'b1, 8'd5,   1'b1, 1'b1, 8'd5, 1'b0};
    vecs[8]  = '{1'b0, 8'd0,   1'b1, 1'b0, 8'd4, 1'b0};
    vecs[9]  = '{1'b0, 8'd0,   1'b1, 1'b1, 8'd5, 1'b0};
    vecs[10] = '{1'b1, 8'd9,   1'b0, 1'b0, 8'd9, 1'b0};
    vecs[11] = '{1'b0, 8'd0,   1'b0, 1'b1, 8'd9, 1'b0};
    vecs[12] = '{1'b0, 8'd0,   1'b1, 1'b1, 8'd0, 1'b1};
    vecs[13] = '{1'b0, 8'd0,   1'b1, 1'b0, 8'd9, 1'b1};
    vecs[14] = '{1'b1, 8'd10,  1'b0, 1'b0, 8'd9, 1'b0};
    vecs[15] = '{1'b1, 8'd3,   1'b0, 1'b0, 8'd3, 1'b0};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset q_out", 32'(q_out), 32'd0);
    chk("reset wrap", 32'(wrap), 32'd0);
    chk("reset fault_lane", 32'(fault_lane), 32'd0);
    chk("reset err_cnt", 32'(err_cnt), 32'd0);
    chk("reset uncorrectable", 32'(uncorrectable), 32'd0);
    rst = 1'b0;

    // Load, step, wrap and clip vectors
    for (int i = 0; i < 16; i++) begin
      load     = vecs[i].load;
      load_val = vecs[i].load_val;
      enable   = vecs[i].enable;
      up_dn    = vecs[i].up_dn;
      tick();
      chk($sformatf("vec%0d q_out", i), 32'(q_out), 32'(vecs[i].exp_q));
      chk($sformatf("vec%0d wrap", i), 32'(wrap), 32'(vecs[i].exp_wrap));
      chk($sformatf("vec%0d fault_lane", i), 32'(fault_lane), 32'd0);
    end
    idle_inputs();

    // Single fault on lane 1 while holding at 3
    inject(2'd1, 8'h10);
    tick();
    idle_inputs();
    chk("single q_out", 32'(q_out), 32'd3);
    chk("single fault_lane", 32'(fault_lane), 32'b010);
    chk("single err1 pre", 32'(lane_err(1)), 32'd0);
    tick();
    chk("single scrubbed", 32'(fault_lane), 32'd0);
    chk("single err1", 32'(lane_err(1)), 32'd1);
    chk("single q_out after", 32'(q_out), 32'd3);

    // inj_lane = 3 is a no-op
    inject(2'd3, 8'hFF);
    tick();
    idle_inputs();
    chk("lane3 fault_lane", 32'(fault_lane), 32'd0);
    chk("lane3 q_out", 32'(q_out), 32'd3);

    // Consecutive single-lane injections are each scrubbed, so never uncorrectable
    inject(2'd0, 8'h01);
    tick();
    chk("dbl first fault", 32'(fault_lane), 32'b001);
    inject(2'd2, 8'h02);
    tick();
    idle_inputs();
    chk("dbl second fault", 32'(fault_lane), 32'b100);
    chk("dbl q_out", 32'(q_out), 32'd3);
    chk("dbl uncorr", 32'(uncorrectable), 32'd0);
    chk("dbl err0", 32'(lane_err(0)), 32'd1);
    tick();
    chk("dbl clean", 32'(fault_lane), 32'd0);
    chk("dbl err2", 32'(lane_err(2)), 32'd1);

    // Saturation of lane 0 counter
    inject(2'd0, 8'h01);
    repeat (20) tick();
    idle_inputs();
    tick();
    chk("sat err0", 32'(lane_err(0)), 32'd15);
    chk("sat err1", 32'(lane_err(1)), 32'd1);
    chk("sat err2", 32'(lane_err(2)), 32'd1);
    chk("sat fault clean", 32'(fault_lane), 32'd0);

    // Triple disagreement cannot be produced through the injection port, so
    // the replicas are forced pairwise different for one edge.
    force dut.r0 = 8'h01;
    force dut.r1 = 8'h02;
    force dut.r2 = 8'h04;
    #1;
    chk("triple fault_lane", 32'(fault_lane), 32'b111);
    chk("triple q_out", 32'(q_out), 32'd0);
    tick();
    chk("triple uncorr", 32'(uncorrectable), 32'd1);
    chk("triple err0 sat", 32'(lane_err(0)), 32'd15);
    chk("triple err1", 32'(lane_err(1)), 32'd2);
    release dut.r0;
    release dut.r1;
    release dut.r2;
    repeat (2) tick();
    chk("sticky q_out", 32'(q_out), 32'd0);
    chk("sticky fault", 32'(fault_lane), 32'd0);
    chk("sticky uncorr", 32'(uncorrectable), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr uncorr", 32'(uncorrectable), 32'd0);
    chk("clr err_cnt", 32'(err_cnt), 32'd0);

    // Set condition and err_clr together: set wins for the flag, counters clear
    force dut.r0 = 8'h01;
    force dut.r1 = 8'h02;
    force dut.r2 = 8'h04;
    err_clr = 1'b1;
    tick();
    chk("setwins uncorr", 32'(uncorrectable), 32'd1);
    chk("setwins err_cnt", 32'(err_cnt), 32'd0);
    release dut.r0;
    release dut.r1;
    release dut.r2;
    err_clr = 1'b0;
    repeat (2) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("setwins cleared", 32'(uncorrectable), 32'd0);
    chk("setwins err clean", 32'(err_cnt), 32'd0);

    // Mid-operation reset with a wrap pulse and a faulted lane pending
    load     = 1'b1;
    load_val = 8'd9;
    inject(2'd0, 8'h80);
    tick();
    chk("pre-rst q_out", 32'(q_out), 32'd9);
    chk("pre-rst fault", 32'(fault_lane), 32'b001);
    idle_inputs();
    enable = 1'b1;
    up_dn  = 1'b1;
    inject(2'd1, 8'h04);
    tick();
    idle_inputs();
    chk("pre-rst wrap", 32'(wrap), 32'd1);
    chk("pre-rst q_out wrap", 32'(q_out), 32'd0);
    chk("pre-rst fault1", 32'(fault_lane), 32'b010);
    chk("pre-rst err0", 32'(lane_err(0)), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst wrap", 32'(wrap), 32'd0);
    chk("async rst fault", 32'(fault_lane), 32'd0);
    chk("async rst q_out", 32'(q_out), 32'd0);
    chk("async rst err_cnt", 32'(err_cnt), 32'd0);
    chk("async rst uncorr", 32'(uncorrectable), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
